// File: rtl/div_unit_pkg.sv
// Shared ALU control codes and helpers used by the execute-stage units.
// The divider only needs the two divide codes; the others identify non-divide work.
package div_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] aluctrl_t;

  localparam aluctrl_t AND_CONTROL  = 5'b00000;
  localparam aluctrl_t OR_CONTROL   = 5'b00001;
  localparam aluctrl_t ADD_CONTROL  = 5'b00010;
  localparam aluctrl_t SUB_CONTROL  = 5'b00110;
  localparam aluctrl_t SLT_CONTROL  = 5'b00111;
  localparam aluctrl_t MULT_CONTROL = 5'b11000;
  localparam aluctrl_t MULTU_CONTROL = 5'b11001;
  localparam aluctrl_t DIV_CONTROL  = 5'b11010;
  localparam aluctrl_t DIVU_CONTROL = 5'b11011;

  // Two's-complement magnitude when neg is set; 0x80000000 maps to itself,
  // which is still the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider: one restoring step per cycle,
// result {hi = remainder, lo = quotient}, with flush/hold pipeline handshake.
module div_unit
  import div_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       alucontrol,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic             flush,
  input  logic             hold,
  output logic [2*XLEN-1:0] hilo,
  output logic             ready,
  output logic             stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [5:0]        counter;
  logic [XLEN-1:0]   quo, rem, dvs;
  logic              neg_q, neg_r;
  logic              start, is_signed;

  logic [XLEN:0]     partial, diff;
  logic              fits;
  logic [XLEN-1:0]   rem_step, quo_step;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign is_signed = (alucontrol == DIV_CONTROL);
  assign start     = ((alucontrol == DIV_CONTROL) || (alucontrol == DIVU_CONTROL)) && !flush;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor only if it fits.
  assign partial  = {rem, quo[XLEN-1]};
  assign diff     = partial - {1'b0, dvs};
  assign fits     = !diff[XLEN];
  assign rem_step = fits ? diff[XLEN-1:0] : partial[XLEN-1:0];
  assign quo_step = {quo[XLEN-2:0], fits};
  assign quo_fix  = magnitude(quo_step, neg_q);
  assign rem_fix  = magnitude(rem_step, neg_r);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next-state defaults to the current state first, so no path leaves
  // state_next unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (b == '0) ? ZERO : BUSY;
      ZERO: state_next = flush ? IDLE : DONE;
      BUSY: begin
        if (flush)                state_next = IDLE;
        else if (counter == 6'd31) state_next = DONE;
      end
      DONE: if (flush || !hold) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == DONE);
    stall = (state == ZERO) || (state == BUSY) || ((state == IDLE) && start);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hilo    <= '0;
    end else begin
      if (state == IDLE && start) begin
        quo     <= magnitude(a, is_signed && a[XLEN-1]);
        dvs     <= magnitude(b, is_signed && b[XLEN-1]);
        rem     <= '0;
        counter <= '0;
        neg_q   <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
        neg_r   <= is_signed && a[XLEN-1];
      end else if (state == BUSY && !flush) begin
        quo     <= quo_step;
        rem     <= rem_step;
        counter <= counter + 6'd1;
      end
      // The result register only moves on entry to DONE, so flushes and
      // hold periods never disturb the last delivered value.
      if (state_next == DONE && state != DONE)
        hilo <= (state == ZERO) ? '0 : {rem_fix, quo_fix};
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, random divides
// against an arithmetic reference model, and flush/hold/reset sequences.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alucontrol;
  logic [31:0] a, b;
  logic        flush, hold;
  logic [63:0] hilo;
  logic        ready, stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .a(a), .b(b),
    .flush(flush), .hold(hold), .hilo(hilo), .ready(ready), .stall(stall)
  );

  typedef struct {
    string       name;
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain truncating division, computed in 64 bits so the
  // most-negative / -1 case wraps instead of trapping.
  function automatic logic [63:0] model(input logic [4:0] ctrl, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [31:0] uq, ur;
    if (y == 32'd0) return 64'h0;
    if (ctrl == DIV_CONTROL) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    uq = x / y;
    ur = x % y;
    return {ur, uq};
  endfunction

  // Present a divide in cycle T (stall must already be high), then cross edge T.
  task automatic start_div(input string name, input logic [4:0] ctrl, input logic [31:0] da, input logic [31:0] db);
    @(negedge clk);
    alucontrol = ctrl; a = da; b = db;
    #1 check({name, " start stall"}, 64'(stall), 64'd1);
    @(posedge clk);
  endtask

  // Wait up to 40 cycles for ready; operands are scrambled meanwhile.
  task automatic wait_ready(output int lat, output bit stall_ok);
    lat = 0; stall_ok = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      alucontrol = ADD_CONTROL; a = $urandom; b = $urandom;
      #1;
      if (ready) begin
        lat = k;
        if (stall) stall_ok = 1'b0;
      end else if (!stall) stall_ok = 1'b0;
    end
  endtask

  task automatic run_div(input string name, input logic [4:0] ctrl, input logic [31:0] da,
                         input logic [31:0] db, input logic [63:0] exp_hilo, input int exp_lat);
    int lat; bit stall_ok;
    start_div(name, ctrl, da, db);
    wait_ready(lat, stall_ok);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " stall"}, 64'(stall_ok), 64'd1);
    check({name, " hilo"}, hilo, exp_hilo);
    @(negedge clk);
    #1 check({name, " idle after"}, 64'({ready, stall}), 64'd0);
  endtask

  vec_t        vecs[6];
  logic [63:0] prev;
  int          lat;
  bit          stall_ok, seen;

  initial begin
    vecs[0] = '{"divu_100_7",  DIVU_CONTROL, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[1] = '{"div_m7_2",    DIV_CONTROL,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[2] = '{"divu_by0",    DIVU_CONTROL, 32'd5,        32'd0,        32'd0,        32'd0,        2};
    vecs[3] = '{"div_ovf",     DIV_CONTROL,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
    vecs[4] = '{"divu_big",    DIVU_CONTROL, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};
    vecs[5] = '{"div_7_m2",    DIV_CONTROL,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};

    rst = 1'b1; flush = 1'b0; hold = 1'b0; alucontrol = ADD_CONTROL; a = '0; b = '0;
    @(negedge clk);
    #1 check("reset outputs", {hilo[61:0], ready, stall}, 64'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_div(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].lat);

    for (int i = 0; i < 12; i++) begin
      logic [4:0]  c;
      logic [31:0] x, y;
      c = ($urandom_range(0, 1) == 1) ? DIV_CONTROL : DIVU_CONTROL;
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = -$urandom_range(1, 15);
        default: y = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), c, x, y, model(c, x, y), (y == 0) ? 2 : 33);
    end

    // Flush mid-divide: annulled, no ready, previous result kept.
    prev = hilo;
    start_div("flush", DIVU_CONTROL, 32'd100, 32'd7);
    seen = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      alucontrol = ADD_CONTROL;
      flush = (k == 10);
      #1;
      if (ready) seen = 1'b1;
      if (k == 11) check("flush stall", 64'(stall), 64'd0);
    end
    check("flush no ready", 64'(seen), 64'd0);
    check("flush hilo kept", hilo, prev);

    // Start together with flush in IDLE must not begin a divide.
    @(negedge clk);
    alucontrol = DIV_CONTROL; a = 32'd9; b = 32'd3; flush = 1'b1;
    #1 check("flush start stall", 64'(stall), 64'd0);
    @(negedge clk);
    alucontrol = ADD_CONTROL; flush = 1'b0;
    #1 check("flush start idle", 64'({ready, stall}), 64'd0);

    // Hold keeps DONE for three extra cycles.
    start_div("hold", DIV_CONTROL, 32'hFFFFFF9C, 32'd7);
    wait_ready(lat, stall_ok);
    check("hold latency", 64'(lat), 64'd33);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check($sformatf("hold cyc%0d", k), {hilo[61:0], ready, stall},
               {model(DIV_CONTROL, 32'hFFFFFF9C, 32'd7), 2'b10} & {62'h3FFFFFFFFFFFFFFF, 2'b11});
      if (k == 2) hold = 1'b0;
    end
    @(negedge clk);
    #1 check("hold release", 64'(ready), 64'd0);

    // Asynchronous reset mid-BUSY.
    start_div("reset", DIVU_CONTROL, 32'd100, 32'd7);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      alucontrol = ADD_CONTROL;
    end
    rst = 1'b1;
    #1 check("reset mid busy", {hilo[61:0], ready, stall}, 64'd0);
    check("reset hilo top", 64'(hilo[63:62]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div("after reset", DIVU_CONTROL, 32'd1000, 32'd33, {32'd10, 32'd30}, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
